fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the opcode decoder. It reads the opcode byte at the program counter from a byte-wide synchronous memory and presents it to the decoder. It then uses the decoder's returned instruction size to fetch 0, 1 or 2 operand bytes. It hands a complete instruction (opcode, operands, its PC and size) downstream over a valid/ready handshake, and accepts PC redirects for JMP/BEQ/BNE.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  out  16  byte address; equals `pc` (combinational from state/pc).
- `mem_rd`  out  1  read strobe; high only in `*_REQ` states.
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after `mem_rd`.
- `dec_opcode`  out  8  to decoder: `mem_rdata` while in OP_WAIT, else latched opcode.
- `dec_instr_size`  in  2  from decoder: 1, 2 or 3; 0 is treated as 1.
- `pc_load`  in  1  redirect request.
- `pc_load_value`  in  16  redirect target.
- `instr_valid`  out  1  complete instruction available.
- `instr_ready`  in  1  downstream accepts.
- `instr_opcode`  out  8  opcode byte.
- `instr_op1`  out  8  first operand byte; 0 if unused.
- `instr_op2`  out  8  second operand byte (abs high byte); 0 if unused.
- `instr_pc`  out  16  address of opcode byte.
- `instr_size`  out  2  1..3.

## Operation
- States: OP_REQ, OP_WAIT, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT, VALID.
- OP_REQ:
  - `mem_rd`=1, `mem_addr`=pc.
  - Latch `instr_pc`<=pc; pc<=pc+1; clear op1/op2.
  - Go to OP_WAIT.
- OP_WAIT:
  - Latch opcode<=`mem_rdata`; latch size<=`dec_instr_size` (0 becomes 1).
  - size 1 -> VALID; else B1_REQ.
- B1_REQ: `mem_rd`=1; pc<=pc+1; go to B1_WAIT.
- B1_WAIT: op1<=`mem_rdata`; size 2 -> VALID; size 3 -> B2_REQ.
- B2_REQ: `mem_rd`=1; pc<=pc+1; go to B2_WAIT.
- B2_WAIT: op2<=`mem_rdata`; go to VALID.
- VALID:
  - `instr_valid`=1; all `instr_*` held stable while `instr_ready`=0.
  - On `instr_ready`=1 -> OP_REQ. pc already points at the next instruction.
- PC arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000; operand bytes may straddle the wrap.
- `pc_load` (any state, highest priority after `rst`):
  - pc<=`pc_load_value`; state<=OP_REQ; partial fetch discarded.
  - `mem_rd` is not asserted in the cycle `pc_load` is high.
- `pc_load` with `instr_valid`&`instr_ready` in the same cycle: the handshake completes (instruction consumed), and the next fetch starts at `pc_load_value`.
- `pc_load` in VALID without `instr_ready`: the held instruction is dropped, never transferred.
- A read in flight when `pc_load` arrives: its returning data is ignored.

## Timing
- Reset (sync, `rst`=1 at rising edge):
  - state=OP_REQ, pc=`RESET_PC`.
  - `instr_valid`=0, `instr_opcode`/`op1`/`op2`=0, `instr_pc`=0, `instr_size`=1.
  - `mem_rd` is low while `rst` is high.
- Reset mid-fetch aborts immediately; the first `mem_rd` comes in the first cycle after `rst` deasserts.
- Latency from OP_REQ cycle to `instr_valid`: size 1 = 2 cycles, size 2 = 4, size 3 = 6.
- Throughput with `instr_ready` tied high: one instruction per (2×size + 1) cycles; VALID lasts 1 cycle.
- `instr_valid` deasserts the cycle after the handshake, or the cycle after `pc_load`.
- `dec_opcode` is combinational from `mem_rdata` in OP_WAIT. The decoder is combinational, so size is sampled in the same cycle.
- Outputs `instr_*` are registered; `mem_addr`/`mem_rd`/`dec_opcode` are combinational.

## Test plan
- Reset with `RESET_PC`=16'h0200, memory[0200]=E8 (INX), ready=1:
  - `mem_rd` at addr 0200 the cycle after reset.
  - 2 cycles later: valid, opcode E8, size 1, op1=op2=0, instr_pc 0200.
  - Next `mem_rd` at 0201.
- Memory A9 05 at 0000:
  - valid on cycle 4 with opcode A9, op1 05, op2 00, size 2.
  - Next fetch at 0002.
- Memory 4C 34 12 at 0010:
  - valid on cycle 6 with op1 34, op2 12, size 3.
  - Then `pc_load`=1, value 1234 with ready=1: handshake counts, next `mem_addr`=1234.
- Backpressure: hold `instr_ready`=0 for 5 cycles in VALID.
  - All `instr_*` stay constant and no `mem_rd` is issued.
  - Release: one transfer, then fetch resumes.
- `pc_load`=1, value 0300, asserted in B1_WAIT of a 3-byte instruction:
  - No `instr_valid` for the aborted instruction.
  - Next cycle OP_REQ with addr 0300.
- Wrap: memory[FFFF]=A5, memory[0000]=10:
  - valid with instr_pc FFFF, op1 10, size 2.
  - Next fetch address 0001.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It reads the opcode byte at pc and gets the instruction
// size from the combinational decoder. It then fetches 0..2 operand bytes and
// presents the whole instruction downstream over a valid/ready handshake.
// Redirects from pc_load abort any fetch in progress.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  dec_opcode,
  input  logic [1:0]  dec_instr_size,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op1,
  output logic [7:0]  instr_op2,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_size
);

  typedef enum logic [2:0] {
    OP_REQ, OP_WAIT, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT, VALID
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [1:0]  size_eff;
  logic        req_state;

  // The decoder reports 0 for unknown opcodes; treat those as single-byte.
  assign size_eff  = (dec_instr_size == 2'd0) ? 2'd1 : dec_instr_size;
  assign req_state = (state == OP_REQ) || (state == B1_REQ) || (state == B2_REQ);

  // Memory request side. A redirect or reset suppresses the strobe so no stale read is issued.
  assign mem_addr   = pc;
  assign mem_rd     = req_state && !pc_load && !rst;
  assign dec_opcode = (state == OP_WAIT) ? mem_rdata : instr_opcode;

  // Fetch sequencer. A redirect overrides every state. Data returning for an
  // aborted read lands while the FSM is back in OP_REQ, so it is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= OP_REQ;
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_opcode <= 8'h00;
      instr_op1    <= 8'h00;
      instr_op2    <= 8'h00;
      instr_pc     <= 16'h0000;
      instr_size   <= 2'd1;
    end else if (pc_load) begin
      pc          <= pc_load_value;
      state       <= OP_REQ;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        OP_REQ: begin
          instr_pc  <= pc;
          pc        <= pc + 16'd1;
          instr_op1 <= 8'h00;
          instr_op2 <= 8'h00;
          state     <= OP_WAIT;
        end
        OP_WAIT: begin
          instr_opcode <= mem_rdata;
          instr_size   <= size_eff;
          if (size_eff == 2'd1) begin
            state       <= VALID;
            instr_valid <= 1'b1;
          end else begin
            state <= B1_REQ;
          end
        end
        B1_REQ: begin
          pc    <= pc + 16'd1;
          state <= B1_WAIT;
        end
        B1_WAIT: begin
          instr_op1 <= mem_rdata;
          if (instr_size == 2'd2) begin
            state       <= VALID;
            instr_valid <= 1'b1;
          end else begin
            state <= B2_REQ;
          end
        end
        B2_REQ: begin
          pc    <= pc + 16'd1;
          state <= B2_WAIT;
        end
        B2_WAIT: begin
          instr_op2   <= mem_rdata;
          state       <= VALID;
          instr_valid <= 1'b1;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= OP_REQ;
          end
        end
        default: begin
          state       <= OP_REQ;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
